// File: rtl/traffic_phase_fsm_if.sv
// -----------------------------------------------------------------------------
// traffic_phase_fsm_if
// Signal bundle between the phase controller, the seconds counter and the
// sensor/lamp board.
//   count        seconds since last reset_count (from the seconds counter)
//   side_car     side-road vehicle sensor, asynchronous level
//   ped_btn      pedestrian push button, asynchronous, active-high
//   reset_count  one-cycle pulse clearing the seconds counter
//   main_light   {red, yellow, green}, one-hot
//   side_light   {red, yellow, green}, one-hot
//   walk         pedestrian walk lamp
//   ped_pending  latched pedestrian request (wait indicator)
//   phase        current FSM state encoding, debug only
// slave  = the phase controller, master = counter/sensor side (or bench).
// -----------------------------------------------------------------------------
interface traffic_phase_fsm_if;
    logic [5:0] count;
    logic       side_car;
    logic       ped_btn;
    logic       reset_count;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic       ped_pending;
    logic [2:0] phase;

    modport master (
        output count, side_car, ped_btn,
        input  reset_count, main_light, side_light, walk, ped_pending, phase
    );

    modport slave (
        input  count, side_car, ped_btn,
        output reset_count, main_light, side_light, walk, ped_pending, phase
    );
endinterface

// File: rtl/traffic_phase_fsm.sv
// -----------------------------------------------------------------------------
// traffic_phase_fsm
// Phase controller for a two-road intersection. Sequences main-road,
// side-road and pedestrian signals from the seconds count and restarts the
// seconds counter on every phase change.
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high
//   bus    traffic_phase_fsm_if.slave (count/sensors in, lamps/pulse out)
// -----------------------------------------------------------------------------
module traffic_phase_fsm #(
    parameter int unsigned T_MAIN_MIN   = 20,
    parameter int unsigned T_MAIN_MAX   = 60,
    parameter int unsigned T_YELLOW     = 3,
    parameter int unsigned T_ALL_RED    = 2,
    parameter int unsigned T_SIDE_GREEN = 15,
    parameter int unsigned T_WALK       = 10
) (
    input  logic               clk,
    input  logic               reset,
    traffic_phase_fsm_if.slave bus
);

    localparam logic [2:0] ALL_RED_A   = 3'd0;
    localparam logic [2:0] MAIN_GREEN  = 3'd1;
    localparam logic [2:0] MAIN_YELLOW = 3'd2;
    localparam logic [2:0] ALL_RED_B   = 3'd3;
    localparam logic [2:0] SIDE_GREEN  = 3'd4;
    localparam logic [2:0] SIDE_YELLOW = 3'd5;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    // Thresholds narrowed to the count width; count saturates at 63, so a
    // saturated count satisfies every >= comparison.
    localparam logic [5:0] MAIN_MIN_C   = 6'(T_MAIN_MIN);
    localparam logic [5:0] MAIN_MAX_C   = 6'(T_MAIN_MAX);
    localparam logic [5:0] YELLOW_C     = 6'(T_YELLOW);
    localparam logic [5:0] ALL_RED_C    = 6'(T_ALL_RED);
    localparam logic [5:0] SIDE_GREEN_C = 6'(T_SIDE_GREEN);
    localparam logic [5:0] WALK_C       = 6'(T_WALK);

    logic [2:0] state;
    logic [2:0] state_next;
    logic       side_s1, side_s2;
    logic       ped_s1, ped_s2, ped_prev;
    logic       ped_edge;
    logic       ped_pending_q;
    logic       walk_grant;
    logic       reset_count_q;
    logic [2:0] main_q, side_q;
    logic       timer_ok;
    logic       enter_side_green;
    logic       exit_side_green;

    // Two-flop synchronizers; ped_prev gives rising-edge detection on the
    // synchronized button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            side_s1  <= 1'b0;
            side_s2  <= 1'b0;
            ped_s1   <= 1'b0;
            ped_s2   <= 1'b0;
            ped_prev <= 1'b0;
        end else begin
            side_s1  <= bus.side_car;
            side_s2  <= side_s1;
            ped_s1   <= bus.ped_btn;
            ped_s2   <= ped_s1;
            ped_prev <= ped_s2;
        end
    end

    assign ped_edge = ped_s2 & ~ped_prev;

    // While reset_count is high the counter has not cleared yet, so count
    // still carries the previous phase's value and must be ignored.
    assign timer_ok = ~reset_count_q;

    always_comb begin
        state_next = state;
        case (state)
            ALL_RED_A:
                if (timer_ok && bus.count >= ALL_RED_C) state_next = MAIN_GREEN;
            MAIN_GREEN:
                if (timer_ok &&
                    ((bus.count >= MAIN_MIN_C && (side_s2 || ped_pending_q)) ||
                     bus.count >= MAIN_MAX_C))
                    state_next = MAIN_YELLOW;
            MAIN_YELLOW:
                if (timer_ok && bus.count >= YELLOW_C) state_next = ALL_RED_B;
            ALL_RED_B:
                if (timer_ok && bus.count >= ALL_RED_C) state_next = SIDE_GREEN;
            SIDE_GREEN:
                if (timer_ok && bus.count >= SIDE_GREEN_C) state_next = SIDE_YELLOW;
            SIDE_YELLOW:
                if (timer_ok && bus.count >= YELLOW_C) state_next = ALL_RED_A;
            default:
                state_next = ALL_RED_A;  // illegal encodings recover unconditionally
        endcase
    end

    assign enter_side_green = (state_next == SIDE_GREEN) && (state != SIDE_GREEN);
    assign exit_side_green  = (state == SIDE_GREEN) && (state_next != SIDE_GREEN);

    function automatic logic [2:0] main_decode(input logic [2:0] s);
        case (s)
            MAIN_GREEN:  main_decode = LIGHT_GREEN;
            MAIN_YELLOW: main_decode = LIGHT_YELLOW;
            default:     main_decode = LIGHT_RED;
        endcase
    endfunction

    function automatic logic [2:0] side_decode(input logic [2:0] s);
        case (s)
            SIDE_GREEN:  side_decode = LIGHT_GREEN;
            SIDE_YELLOW: side_decode = LIGHT_YELLOW;
            default:     side_decode = LIGHT_RED;
        endcase
    endfunction

    // Lights are decoded from the next state so they change on the same edge
    // as the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ALL_RED_A;
            reset_count_q <= 1'b0;
            main_q        <= LIGHT_RED;
            side_q        <= LIGHT_RED;
            ped_pending_q <= 1'b0;
            walk_grant    <= 1'b0;
        end else begin
            state         <= state_next;
            reset_count_q <= (state_next != state);
            main_q        <= main_decode(state_next);
            side_q        <= side_decode(state_next);

            // A button edge coinciding with SIDE_GREEN entry wins, so that
            // request is carried into the next cycle of phases.
            if (ped_edge)
                ped_pending_q <= 1'b1;
            else if (enter_side_green)
                ped_pending_q <= 1'b0;

            if (enter_side_green)
                walk_grant <= ped_pending_q;
            else if (exit_side_green)
                walk_grant <= 1'b0;
        end
    end

    assign bus.reset_count = reset_count_q;
    assign bus.main_light  = main_q;
    assign bus.side_light  = side_q;
    assign bus.ped_pending = ped_pending_q;
    assign bus.phase       = state;
    assign bus.walk        = (state == SIDE_GREEN) && walk_grant && (bus.count < WALK_C);

endmodule

// File: tb/tb_traffic_phase_fsm.sv
module tb_traffic_phase_fsm;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    traffic_phase_fsm_if bus ();

    traffic_phase_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drive count, take one clock, sample 1 ns after the edge.
    task automatic step(input logic [5:0] c);
        bus.count = c;
        @(posedge clk);
        #1;
    endtask

    // Enter a phase with count c seen, then count clears during reset_count.
    task automatic enter(input logic [5:0] c);
        step(c);
        step(6'd0);
    endtask

    task automatic test_reset;
        bus.count = 6'd0; bus.side_car = 1'b0; bus.ped_btn = 1'b0;
        reset = 1'b1;
        step(6'd0); step(6'd0);
        checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL reset_phase got %0d exp 0", bus.phase); end
        checks++; if (bus.main_light !== 3'b100) begin errors++; $display("FAIL reset_main got %b exp 100", bus.main_light); end
        checks++; if (bus.side_light !== 3'b100) begin errors++; $display("FAIL reset_side got %b exp 100", bus.side_light); end
        checks++; if (bus.walk !== 1'b0) begin errors++; $display("FAIL reset_walk got %b exp 0", bus.walk); end
        checks++; if (bus.reset_count !== 1'b0) begin errors++; $display("FAIL reset_rc got %b exp 0", bus.reset_count); end
        checks++; if (bus.ped_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", bus.ped_pending); end
        reset = 1'b0;
    endtask

    task automatic test_all_red_a;
        step(6'd1);
        checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL ara_hold got %0d exp 0", bus.phase); end
        step(6'd2);
        checks++; if (bus.phase !== 3'd1) begin errors++; $display("FAIL ara_exit got %0d exp 1", bus.phase); end
        checks++; if (bus.main_light !== 3'b001) begin errors++; $display("FAIL ara_main got %b exp 001", bus.main_light); end
        checks++; if (bus.side_light !== 3'b100) begin errors++; $display("FAIL ara_side got %b exp 100", bus.side_light); end
        checks++; if (bus.reset_count !== 1'b1) begin errors++; $display("FAIL ara_rc_hi got %b exp 1", bus.reset_count); end
        step(6'd0);
        checks++; if (bus.reset_count !== 1'b0) begin errors++; $display("FAIL ara_rc_lo got %b exp 0", bus.reset_count); end
        checks++; if (bus.phase !== 3'd1) begin errors++; $display("FAIL ara_stay got %0d exp 1", bus.phase); end
    endtask

    task automatic test_main_max;
        for (int c = 20; c < 60; c++) begin
            step(6'(c));
            checks++; if (bus.phase !== 3'd1) begin errors++; $display("FAIL max_hold c=%0d got %0d exp 1", c, bus.phase); end
        end
        step(6'd60);
        checks++; if (bus.phase !== 3'd2) begin errors++; $display("FAIL max_exit got %0d exp 2", bus.phase); end
        checks++; if (bus.main_light !== 3'b010) begin errors++; $display("FAIL max_yellow got %b exp 010", bus.main_light); end
        step(6'd0);
        step(6'd3);
        checks++; if (bus.phase !== 3'd3) begin errors++; $display("FAIL max_arb got %0d exp 3", bus.phase); end
        checks++; if (bus.main_light !== 3'b100) begin errors++; $display("FAIL max_arb_main got %b exp 100", bus.main_light); end
        step(6'd0);
        step(6'd2);
        checks++; if (bus.phase !== 3'd4) begin errors++; $display("FAIL max_sg got %0d exp 4", bus.phase); end
        checks++; if (bus.side_light !== 3'b001) begin errors++; $display("FAIL max_sg_side got %b exp 001", bus.side_light); end
        checks++; if (bus.main_light !== 3'b100) begin errors++; $display("FAIL max_sg_main got %b exp 100", bus.main_light); end
        step(6'd0);
        for (int c = 1; c < 15; c++) begin
            step(6'(c));
            checks++; if (bus.walk !== 1'b0 || bus.phase !== 3'd4)
                begin errors++; $display("FAIL nowalk c=%0d walk %b phase %0d exp 0/4", c, bus.walk, bus.phase); end
        end
        step(6'd15);
        checks++; if (bus.phase !== 3'd5) begin errors++; $display("FAIL sy got %0d exp 5", bus.phase); end
        checks++; if (bus.side_light !== 3'b010) begin errors++; $display("FAIL sy_side got %b exp 010", bus.side_light); end
        step(6'd0);
        step(6'd3);
        checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL sy_exit got %0d exp 0", bus.phase); end
        step(6'd0);
        enter(6'd2);
    endtask

    task automatic test_side_car;
        bus.side_car = 1'b1;
        step(6'd5); step(6'd5);
        for (int c = 6; c < 20; c++) begin
            step(6'(c));
            checks++; if (bus.phase !== 3'd1) begin errors++; $display("FAIL car_hold c=%0d got %0d exp 1", c, bus.phase); end
        end
        step(6'd20);
        checks++; if (bus.phase !== 3'd2) begin errors++; $display("FAIL car_exit got %0d exp 2", bus.phase); end
        bus.side_car = 1'b0;
        step(6'd0);
        enter(6'd3); enter(6'd2); enter(6'd15); enter(6'd3); enter(6'd2);
    endtask

    task automatic test_ped;
        bus.ped_btn = 1'b1;
        step(6'd5);
        bus.ped_btn = 1'b0;
        checks++; if (bus.ped_pending !== 1'b0) begin errors++; $display("FAIL ped_lat1 got %b exp 0", bus.ped_pending); end
        step(6'd5);
        checks++; if (bus.ped_pending !== 1'b0) begin errors++; $display("FAIL ped_lat2 got %b exp 0", bus.ped_pending); end
        step(6'd5);
        checks++; if (bus.ped_pending !== 1'b1) begin errors++; $display("FAIL ped_lat3 got %b exp 1", bus.ped_pending); end
        step(6'd20);
        checks++; if (bus.phase !== 3'd2) begin errors++; $display("FAIL ped_exit got %0d exp 2", bus.phase); end
        step(6'd0);
        enter(6'd3);
        step(6'd2);
        checks++; if (bus.phase !== 3'd4) begin errors++; $display("FAIL ped_sg got %0d exp 4", bus.phase); end
        checks++; if (bus.ped_pending !== 1'b0) begin errors++; $display("FAIL ped_clr got %b exp 0", bus.ped_pending); end
        step(6'd0);
        for (int c = 1; c < 10; c++) begin
            step(6'(c));
            checks++; if (bus.walk !== 1'b1) begin errors++; $display("FAIL walk_on c=%0d got %b exp 1", c, bus.walk); end
        end
        step(6'd10);
        checks++; if (bus.walk !== 1'b0) begin errors++; $display("FAIL walk_off got %b exp 0", bus.walk); end
        enter(6'd15); enter(6'd3); enter(6'd2);
    endtask

    task automatic test_simultaneous;
        enter(6'd60);
        enter(6'd3);
        bus.ped_btn = 1'b1;
        step(6'd0); step(6'd0);
        step(6'd2);
        bus.ped_btn = 1'b0;
        checks++; if (bus.phase !== 3'd4) begin errors++; $display("FAIL sim_sg got %0d exp 4", bus.phase); end
        checks++; if (bus.ped_pending !== 1'b1) begin errors++; $display("FAIL sim_pending got %b exp 1", bus.ped_pending); end
        checks++; if (bus.walk !== 1'b0) begin errors++; $display("FAIL sim_walk got %b exp 0", bus.walk); end
        step(6'd0);
        enter(6'd15); enter(6'd3); enter(6'd2);
        step(6'd20);
        checks++; if (bus.phase !== 3'd2) begin errors++; $display("FAIL sim_carry got %0d exp 2", bus.phase); end
        step(6'd0);
        enter(6'd3);
        step(6'd2);
        checks++; if (bus.ped_pending !== 1'b0 || bus.walk !== 1'b1)
            begin errors++; $display("FAIL sim_served pending %b walk %b exp 0/1", bus.ped_pending, bus.walk); end
        step(6'd0);
        enter(6'd15); enter(6'd3); enter(6'd2);
    endtask

    task automatic test_stale;
        logic [2:0] seq [6];
        seq = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        for (int i = 0; i < 6; i++) begin
            step(6'd63);
            checks++; if (bus.phase !== seq[i] || bus.reset_count !== 1'b1)
                begin errors++; $display("FAIL stale_adv i=%0d phase %0d rc %b exp %0d/1", i, bus.phase, bus.reset_count, seq[i]); end
            step(6'd63);
            checks++; if (bus.phase !== seq[i] || bus.reset_count !== 1'b0)
                begin errors++; $display("FAIL stale_mask i=%0d phase %0d rc %b exp %0d/0", i, bus.phase, bus.reset_count, seq[i]); end
        end
        step(6'd0);
    endtask

    task automatic test_illegal;
        force dut.state = 3'd7;
        #1;
        release dut.state;
        checks++; if (bus.phase !== 3'd7) begin errors++; $display("FAIL ill_forced got %0d exp 7", bus.phase); end
        step(6'd0);
        checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL ill_recover got %0d exp 0", bus.phase); end
        checks++; if (bus.main_light !== 3'b100 || bus.side_light !== 3'b100)
            begin errors++; $display("FAIL ill_lights got %b/%b exp 100/100", bus.main_light, bus.side_light); end
        step(6'd0);
    endtask

    task automatic test_async_reset;
        enter(6'd2); enter(6'd60); enter(6'd3); enter(6'd2);
        step(6'd5);
        checks++; if (bus.phase !== 3'd4) begin errors++; $display("FAIL ar_pre got %0d exp 4", bus.phase); end
        #1 reset = 1'b1;
        #1;
        checks++; if (bus.phase !== 3'd0) begin errors++; $display("FAIL ar_phase got %0d exp 0", bus.phase); end
        checks++; if (bus.main_light !== 3'b100 || bus.side_light !== 3'b100)
            begin errors++; $display("FAIL ar_lights got %b/%b exp 100/100", bus.main_light, bus.side_light); end
        checks++; if (bus.walk !== 1'b0 || bus.reset_count !== 1'b0 || bus.ped_pending !== 1'b0)
            begin errors++; $display("FAIL ar_misc walk %b rc %b pend %b exp 0/0/0", bus.walk, bus.reset_count, bus.ped_pending); end
        step(6'd0);
        reset = 1'b0;
        step(6'd2);
        checks++; if (bus.phase !== 3'd1) begin errors++; $display("FAIL ar_restart got %0d exp 1", bus.phase); end
    endtask

    initial begin
        test_reset;
        test_all_red_a;
        test_main_max;
        test_side_car;
        test_ped;
        test_simultaneous;
        test_stale;
        test_illegal;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_phase_fsm.md
# traffic_phase_fsm

Phase controller for the two-road intersection: consumes the 6-bit seconds count from the one-second counter and sequences main-road, side-road and pedestrian signals. It drives the counter's `reset_count` so that every phase is timed from zero. It sits directly downstream of the seconds counter, and its light outputs go straight to the board LED/relay drivers.

## Interface
- `T_MAIN_MIN`, 20: minimum main-road green, seconds
- `T_MAIN_MAX`, 60: forced main-road green end, seconds; must be ≤ 63
- `T_YELLOW`, 3: yellow duration for either road, seconds
- `T_ALL_RED`, 2: all-red clearance, seconds
- `T_SIDE_GREEN`, 15: side-road green, seconds
- `T_WALK`, 10: walk duration, seconds; must be ≤ `T_SIDE_GREEN`
- `clk`  in  1  system clock, 50 MHz
- `reset`  in  1  asynchronous, active-high
- `count`  in  6  seconds elapsed since last `reset_count`, from the seconds counter
- `side_car`  in  1  side-road vehicle sensor, asynchronous level
- `ped_btn`  in  1  pedestrian push button, asynchronous, active-high
- `reset_count`  out  1  one-cycle pulse that clears the seconds counter
- `main_light`  out  3  {red, yellow, green}, one-hot
- `side_light`  out  3  {red, yellow, green}, one-hot
- `walk`  out  1  pedestrian walk lamp
- `ped_pending`  out  1  latched pedestrian request, for the wait-indicator LED
- `phase`  out  3  current state encoding, for debug

## Operation
- Input conditioning:
  - `side_car` and `ped_btn` each pass through a 2-flop synchronizer.
  - A rising edge of synchronized `ped_btn` sets `ped_pending`.
  - `ped_pending` clears on the cycle the FSM enters SIDE_GREEN. That same entry sets the internal `walk_grant` flag; `walk_grant` clears on exit from SIDE_GREEN.
- States and exit conditions, in cycle order. `timer_ok = (reset_count == 0)`.
  - ALL_RED_A (reset state, encoding 0) → MAIN_GREEN when `count ≥ T_ALL_RED`.
  - MAIN_GREEN (1) → MAIN_YELLOW when either:
    - `count ≥ T_MAIN_MIN` and (`side_car_s` or `ped_pending`), or
    - `count ≥ T_MAIN_MAX`.
  - MAIN_YELLOW (2) → ALL_RED_B when `count ≥ T_YELLOW`.
  - ALL_RED_B (3) → SIDE_GREEN when `count ≥ T_ALL_RED`.
  - SIDE_GREEN (4) → SIDE_YELLOW when `count ≥ T_SIDE_GREEN`.
  - SIDE_YELLOW (5) → ALL_RED_A when `count ≥ T_YELLOW`.
  - Every exit additionally requires `timer_ok`.
  - Encodings 6 and 7 are illegal and go to ALL_RED_A on the next clock.
- `reset_count` is registered: high for exactly the one cycle after every state change, low otherwise. While it is high, all count comparisons are masked, because `count` still holds the stale previous-phase value.
- Light decode, registered, from the current state:
  - `main_light`: green (001) in MAIN_GREEN, yellow (010) in MAIN_YELLOW, red (100) otherwise.
  - `side_light`: green in SIDE_GREEN, yellow in SIDE_YELLOW, red otherwise.
  - Both roads are never non-red in the same cycle.
- `walk` = 1 only while in SIDE_GREEN, `walk_grant` = 1, and `count < T_WALK`.
- A pedestrian press while in SIDE_GREEN, SIDE_YELLOW or ALL_RED_A latches `ped_pending` and is served in the next cycle of phases. It does not extend the current green.
- `count` saturates upstream at 63. The FSM treats 63 as ≥ any parameter.

## Timing
- Reset values:
  - phase = ALL_RED_A
  - `main_light` = 100, `side_light` = 100
  - `walk` = 0, `reset_count` = 0, `ped_pending` = 0
  - synchronizers = 0, `walk_grant` = 0
- Reset asserted mid-phase: all outputs return to their reset values immediately (asynchronously). On deassertion, timing restarts in ALL_RED_A from the count supplied by the counter, which shares the same reset.
- Transition latency:
  - The exit condition is evaluated true at clock edge N. The state changes and the lights update at edge N.
  - `reset_count` is high from N to N+1.
  - Comparisons resume at N+2.
- Input latency:
  - `side_car` to decision: 2 cycles.
  - `ped_btn` edge to `ped_pending` high: 3 cycles.
- Simultaneous events:
  - A button edge on the same cycle as entry to SIDE_GREEN: entry clears first, then the edge sets `ped_pending` = 1 again, so a new request is carried into the next cycle of phases.
  - `side_car` dropping after `T_MAIN_MIN` simply holds MAIN_GREEN until `T_MAIN_MAX`.

## Test plan
- Reset released, bench drives `count` as a stepped input: with count = 2 the FSM goes to MAIN_GREEN, `main_light` = 001, and `reset_count` pulses for 1 cycle.
- MAIN_GREEN, `side_car` = 0, no press: count 20..59 keeps green; count = 60 → MAIN_YELLOW (010). Then count 3 → ALL_RED_B, count 2 → SIDE_GREEN, with `side_light` = 001 and `main_light` = 100.
- `side_car` = 1 at count = 5: no exit until count = 20, then MAIN_YELLOW on the same edge the value 20 is seen (after the 2-cycle sync).
- `ped_btn` pulse during MAIN_GREEN: `ped_pending` = 1 three cycles later. Entry to SIDE_GREEN clears it; `walk` = 1 for count 0..9 and 0 at count 10. Without a press, `walk` stays 0 through SIDE_GREEN.
- Stale count: hold count = 63 across a transition; the FSM must not skip a state while `reset_count` is high. After it drops, advancement occurs exactly one state per timed phase.
- Force the phase register to 7 via the bench: ALL_RED_A on the next edge with both lights 100. Assert reset mid-SIDE_GREEN: lights go to 100/100 with no clock edge.
